// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers init values and instructions from a host, replays them
// to a datapath (init phase, then execute phase) and collects the ALU results in program order.
module instr_sequencer #(
    parameter int INIT_DEPTH = 8,
    parameter int PROG_DEPTH = 16,
    parameter int ALU_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic        load_is_init,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] Instruction,
    output logic [15:0] DataInit,
    output logic        InitSel,
    input  logic [15:0] ALUOut,
    output logic        result_valid,
    output logic [15:0] result_data,
    output logic [3:0]  result_index
);

    localparam int MAXD = (PROG_DEPTH > INIT_DEPTH) ? PROG_DEPTH : INIT_DEPTH;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int IW   = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
    localparam int PW   = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_EXEC, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     init_count_q, prog_count_q;
    logic [15:0]       init_mem [INIT_DEPTH];
    logic [15:0]       prog_mem [PROG_DEPTH];
    logic [ALU_LAT-1:0] vld_q;
    logic [3:0]        idx_pipe_q [ALU_LAT];
    logic              issue_s, clear_s, load_fire_s;
    logic              busy_q, done_q, result_valid_q;
    logic [15:0]       result_data_q;
    logic [3:0]        result_index_q;

    // Load handshake: only idle, and only while the targeted buffer has room.
    always_comb begin
        load_ready = 1'b0;
        if (state_q == S_IDLE) begin
            if (load_is_init) begin
                load_ready = (init_count_q < CW'(INIT_DEPTH));
            end else begin
                load_ready = (prog_count_q < CW'(PROG_DEPTH));
            end
        end else begin
            load_ready = 1'b0;
        end
    end

    assign load_fire_s = load_valid & load_ready;

    // Buffer storage; contents are deliberately never cleared, only the counts.
    always_ff @(posedge clk) begin
        if (load_fire_s && load_is_init) begin
            init_mem[init_count_q[IW-1:0]] <= load_data;
        end
        if (load_fire_s && !load_is_init) begin
            prog_mem[prog_count_q[PW-1:0]] <= load_data;
        end
    end

    // Fill counters, cleared when a run completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_count_q <= '0;
            prog_count_q <= '0;
        end else if (clear_s) begin
            init_count_q <= '0;
            prog_count_q <= '0;
        end else begin
            if (load_fire_s && load_is_init) begin
                init_count_q <= init_count_q + CW'(1);
            end
            if (load_fire_s && !load_is_init) begin
                prog_count_q <= prog_count_q + CW'(1);
            end
        end
    end

    // Next-state logic for the run sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        issue_s = 1'b0;
        clear_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (prog_count_q != CW'(0))) begin
                    state_d = (init_count_q != CW'(0)) ? S_INIT : S_EXEC;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (idx_q == init_count_q - CW'(1)) begin
                    state_d = S_EXEC;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            S_EXEC: begin
                issue_s = 1'b1;
                if (idx_q == prog_count_q - CW'(1)) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            S_DRAIN: begin
                // Leave once the final result is sitting in the output register.
                if (vld_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                clear_s = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, index and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Datapath drive decoded from the registered state and index.
    always_comb begin
        Instruction = 16'h0000;
        DataInit    = 16'h0000;
        InitSel     = 1'b1;
        case (state_q)
            S_INIT: begin
                DataInit = init_mem[idx_q[IW-1:0]];
                InitSel  = 1'b0;
            end
            S_EXEC: begin
                Instruction = prog_mem[idx_q[PW-1:0]];
            end
            default: begin
                Instruction = 16'h0000;
            end
        endcase
    end

    // Issue-tracking pipeline matching the ALU latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < ALU_LAT; i++) begin
                idx_pipe_q[i] <= 4'd0;
            end
        end else begin
            vld_q[0]      <= issue_s;
            idx_pipe_q[0] <= idx_q[3:0];
            for (int i = 1; i < ALU_LAT; i++) begin
                vld_q[i]      <= vld_q[i-1];
                idx_pipe_q[i] <= idx_pipe_q[i-1];
            end
        end
    end

    // Result capture register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_valid_q <= 1'b0;
            result_data_q  <= 16'h0000;
            result_index_q <= 4'd0;
        end else begin
            result_valid_q <= vld_q[ALU_LAT-1];
            if (vld_q[ALU_LAT-1]) begin
                result_data_q  <= ALUOut;
                result_index_q <= idx_pipe_q[ALU_LAT-1];
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign result_index = result_index_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a queue-based model predicts the per-cycle
// datapath drive and result stream of each run; stimulus is randomized where possible.
module tb_instr_sequencer;

    localparam int INIT_DEPTH = 8;
    localparam int PROG_DEPTH = 16;
    localparam int ALU_LAT    = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid, load_is_init, load_ready, start, busy, done, InitSel, result_valid;
    logic [15:0] load_data, Instruction, DataInit, ALUOut, result_data;
    logic [3:0]  result_index;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_init[$];
    logic [15:0] m_prog[$];
    logic [15:0] key = 16'h0001;
    logic [15:0] cur_instr = 16'h0000;
    logic [15:0] hist [ALU_LAT];

    instr_sequencer #(.INIT_DEPTH(INIT_DEPTH), .PROG_DEPTH(PROG_DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_is_init(load_is_init),
        .load_data(load_data), .load_ready(load_ready), .start(start), .busy(busy), .done(done),
        .Instruction(Instruction), .DataInit(DataInit), .InitSel(InitSel), .ALUOut(ALUOut),
        .result_valid(result_valid), .result_data(result_data), .result_index(result_index)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: ALUOut = instruction issued ALU_LAT cycles earlier, plus key.
    always @(negedge clk) cur_instr = Instruction;
    always @(posedge clk) begin
        for (int i = ALU_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = cur_instr;
        #1 ALUOut = hist[ALU_LAT-1] + key;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input bit is_init, input logic [15:0] d);
        bit exp_ready;
        @(negedge clk);
        load_valid = 1'b1; load_is_init = is_init; load_data = d;
        #1;
        exp_ready = is_init ? (m_init.size() < INIT_DEPTH) : (m_prog.size() < PROG_DEPTH);
        check_val("load_ready", {31'd0, load_ready}, {31'd0, exp_ready});
        @(posedge clk);
        if (exp_ready) begin
            if (is_init) m_init.push_back(d);
            else m_prog.push_back(d);
        end
        #1 load_valid = 1'b0;
    endtask

    task automatic do_run(input bit inject);
        int nI, nP, total, k;
        logic [15:0] exp_ins, exp_di, exp_res;
        logic        exp_sel;
        nI = m_init.size(); nP = m_prog.size();
        total = nI + nP + ALU_LAT + 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (nP == 0) begin
            for (int c = 0; c < 3; c++) begin
                check_val("idle_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
            end
            return;
        end
        for (int c = 1; c <= total + 1; c++) begin
            if (c > 1) @(negedge clk);
            load_valid = 1'b0; start = 1'b0;
            if (c <= nI) begin
                exp_sel = 1'b0; exp_di = m_init[c-1]; exp_ins = 16'h0000;
            end else if (c <= nI + nP) begin
                exp_sel = 1'b1; exp_di = 16'h0000; exp_ins = m_prog[c-nI-1];
            end else begin
                exp_sel = 1'b1; exp_di = 16'h0000; exp_ins = 16'h0000;
            end
            check_val($sformatf("InitSel@%0d", c), {31'd0, InitSel}, {31'd0, exp_sel});
            check_val($sformatf("DataInit@%0d", c), {16'd0, DataInit}, {16'd0, exp_di});
            check_val($sformatf("Instruction@%0d", c), {16'd0, Instruction}, {16'd0, exp_ins});
            check_val($sformatf("busy@%0d", c), {31'd0, busy}, (c <= total) ? 32'd1 : 32'd0);
            check_val($sformatf("done@%0d", c), {31'd0, done}, (c == total) ? 32'd1 : 32'd0);
            k = c - (nI + 1) - ALU_LAT - 1;
            check_val($sformatf("result_valid@%0d", c), {31'd0, result_valid},
                      (k >= 0 && k < nP) ? 32'd1 : 32'd0);
            if (k >= 0 && k < nP) begin
                exp_res = m_prog[k] + key;
                check_val($sformatf("result_data@%0d", c), {16'd0, result_data}, {16'd0, exp_res});
                check_val($sformatf("result_index@%0d", c), {28'd0, result_index}, k);
            end
            if (inject && nP >= 2 && c == nI + 2) begin
                load_valid = 1'b1; load_is_init = 1'($urandom_range(0, 1));
                load_data = 16'($urandom); start = 1'b1;
                #1 check_val("busy_load_ready", {31'd0, load_ready}, 32'd0);
            end
        end
        m_init.delete(); m_prog.delete();
    endtask

    task automatic reset_mid_run();
        int nI;
        load_word(1'b1, 16'($urandom));
        load_word(1'b1, 16'($urandom));
        for (int i = 0; i < 10; i++) load_word(1'b0, 16'($urandom));
        nI = m_init.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c < nI + 1 + 5; c++) @(negedge clk);
        check_val("pre_reset_instr", {16'd0, Instruction}, {16'd0, m_prog[5]});
        reset = 1'b0;
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check_val("rst_result_data", {16'd0, result_data}, 32'd0);
        check_val("rst_instr", {16'd0, Instruction}, 32'd0);
        check_val("rst_initsel", {31'd0, InitSel}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("rst_hold_done", {31'd0, done}, 32'd0);
            check_val("rst_hold_rv", {31'd0, result_valid}, 32'd0);
        end
        reset = 1'b1;
        m_init.delete(); m_prog.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("post_rst_done", {31'd0, done}, 32'd0);
            check_val("post_rst_rv", {31'd0, result_valid}, 32'd0);
        end
        load_is_init = 1'b1; #1 check_val("post_rst_ready_init", {31'd0, load_ready}, 32'd1);
        load_is_init = 1'b0; #1 check_val("post_rst_ready_prog", {31'd0, load_ready}, 32'd1);
        do_run(1'b0);
    endtask

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_is_init = 1'b0; load_data = 16'h0000;
        start = 1'b0; ALUOut = 16'h0000;
        for (int i = 0; i < ALU_LAT; i++) hist[i] = 16'h0000;
        #12;
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_result_valid", {31'd0, result_valid}, 32'd0);
        check_val("reset_result_data", {16'd0, result_data}, 32'd0);
        check_val("reset_result_index", {28'd0, result_index}, 32'd0);
        check_val("reset_instr", {16'd0, Instruction}, 32'd0);
        check_val("reset_datainit", {16'd0, DataInit}, 32'd0);
        check_val("reset_initsel", {31'd0, InitSel}, 32'd1);
        check_val("reset_load_ready", {31'd0, load_ready}, 32'd1);
        @(negedge clk); reset = 1'b1;

        key = 16'h0001;
        load_word(1'b1, 16'h0011); load_word(1'b1, 16'h0022); load_word(1'b1, 16'h0033);
        load_word(1'b0, 16'h1234); load_word(1'b0, 16'h5678);
        do_run(1'b0);

        do_run(1'b0);
        load_word(1'b0, 16'hA5A5);
        do_run(1'b0);

        key = 16'($urandom);
        for (int i = 0; i < 17; i++) load_word(1'b0, 16'($urandom));
        do_run(1'b1);

        for (int r = 0; r < 6; r++) begin
            int ni, np;
            key = 16'($urandom);
            ni = $urandom_range(0, INIT_DEPTH + 1);
            np = $urandom_range(1, 6);
            for (int i = 0; i < ni; i++) load_word(1'b1, 16'($urandom));
            for (int i = 0; i < np; i++) load_word(1'b0, 16'($urandom));
            do_run(1'($urandom_range(0, 1)));
        end

        reset_mid_run();
        load_word(1'b0, 16'h0F0F);
        do_run(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: INIT_DEPTH, 8, number of entries in the init-value buffer.
REQ-002 Parameter: PROG_DEPTH, 16, number of entries in the instruction buffer.
REQ-003 Parameter: ALU_LAT, 1, cycles from instruction issue to valid ALUOut (range 1-4).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 load_valid  input  1  host offers a word to load.
REQ-007 load_is_init  input  1  1 = word goes to init buffer; 0 = word goes to instruction buffer.
REQ-008 load_data  input  16  word being loaded.
REQ-009 load_ready  output  1  word is accepted when load_valid and load_ready are both 1 at a rising edge.
REQ-010 start  input  1  begin a run; sampled only in IDLE.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle pulse at end of run.
REQ-013 Instruction  output  16  instruction driven to the datapath.
REQ-014 DataInit  output  16  init value driven to the datapath.
REQ-015 InitSel  output  1  0 = datapath register-init cycle; 1 = execute cycle.
REQ-016 ALUOut  input  16  datapath ALU result.
REQ-017 result_valid  output  1  result_data/result_index hold a captured ALUOut this cycle.
REQ-018 result_data  output  16  captured ALUOut.
REQ-019 result_index  output  4  program index of the instruction that produced result_data.

Function
REQ-020 States SHALL be IDLE, INIT, EXEC, DRAIN, DONE.
REQ-021 load_ready SHALL be 1 only in IDLE when the targeted buffer is not full; words offered at other times SHALL be dropped, with no buffer or count change.
REQ-022 Each buffer SHALL fill in order from entry 0 and keep a count; init_count ranges 0..INIT_DEPTH and prog_count ranges 0..PROG_DEPTH.
REQ-023 In IDLE, start=1 with prog_count=0 SHALL be ignored.
REQ-024 In IDLE, start=1 with prog_count>0 SHALL go to INIT if init_count>0, else to EXEC.
REQ-025 INIT SHALL present one init entry per cycle (DataInit=entry, InitSel=0, Instruction=0) for exactly init_count cycles, then go to EXEC.
REQ-026 EXEC SHALL present one instruction per cycle (Instruction=entry, InitSel=1, DataInit=0) for exactly prog_count cycles, then go to DRAIN.
REQ-027 For the instruction issued at cycle t, ALUOut SHALL be sampled at cycle t+ALU_LAT and presented registered one cycle later, with result_valid=1 and result_index=its program index.
REQ-028 Results SHALL appear in program order, one per cycle, with no gaps.
REQ-029 DRAIN SHALL last until the last result_valid has been asserted, then go to DONE.
REQ-030 DONE SHALL last one cycle with done=1, clear init_count and prog_count, and return to IDLE.
REQ-031 In IDLE, DRAIN and DONE, outputs SHALL be Instruction=0, DataInit=0, InitSel=1.
REQ-032 start asserted while busy=1 SHALL have no effect.
REQ-033 Buffer contents SHALL NOT be cleared (only counts); stale entries beyond a count SHALL never be issued.

Reset
REQ-034 reset=0 SHALL force, asynchronously: state IDLE, init_count=0, prog_count=0, all result pipeline valids 0.
REQ-035 Output values during reset SHALL be: busy=0, done=0, result_valid=0, result_data=0, result_index=0, Instruction=0, DataInit=0, InitSel=1, load_ready=1.
REQ-036 Reset asserted mid-run SHALL abort the run with no done pulse; in-flight results SHALL be discarded.

Verification
REQ-037 Load 3 init words (0x0011,0x0022,0x0033) and 2 instructions (0x1234,0x5678), then start -> InitSel=0 for 3 cycles with DataInit 0x0011/0x0022/0x0033, then InitSel=1 for 2 cycles with 0x1234/0x5678.
REQ-038 Same run with ALUOut driven as instruction+1 after ALU_LAT -> result_valid for 2 cycles, results 0x1235 (index 0) and 0x5679 (index 1); done pulses once, then busy=0.
REQ-039 Load 17 instructions -> load_ready=0 after the 16th; run issues exactly 16 instructions and returns result_index 0..15.
REQ-040 start with prog_count=0 -> busy stays 0; start with init_count=0 and 1 instruction -> EXEC directly, no InitSel=0 cycle.
REQ-041 Assert reset during EXEC at instruction 5 of 10 -> immediately IDLE, result_valid=0, no done; after release, load_ready=1 and counts=0.
REQ-042 load_valid=1 and start=1 during EXEC -> word dropped, run unaffected; the next run issues only newly loaded words.
